imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory before the single-cycle core runs. It accepts a byte stream from the host link over a valid/ready handshake and assembles bytes little-endian into 32-bit instructions. Each instruction is written to consecutive word-aligned byte addresses, starting at 0x00000000, which is the same addressing the core uses on `PC_out`. While loading, the block holds the core in reset.

## Interface

Parameters:
- MEM_DEPTH, 64, instruction memory size in 32-bit words; also the maximum legal `word_count`.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE.
- word_count  in  16  number of instructions to load; sampled on the `start` cycle.
- byte_valid  in  1  `byte_data` is valid.
- byte_data  in  8  next program byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the word being written; always a multiple of 4.
- mem_wdata  out  32  assembled instruction.
- cpu_hold  out  1  holds the core in reset while high.
- busy  out  1  load in progress.
- done  out  1  sticky; last load completed.
- error  out  1  sticky; last `start` carried an illegal `word_count`.

## Operation

- All outputs are registered.
- Reset values: every output is 0. FSM in IDLE; byte index and word index are 0.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `byte_ready`=0.
  - `start` with 1 ≤ `word_count` ≤ MEM_DEPTH: latch the count, clear `done` and `error`, set `busy`=1 and `cpu_hold`=1, go to RECV.
  - `start` with `word_count`=0 or `word_count` > MEM_DEPTH: set `error`=1, clear `done`, stay in IDLE, issue no write.
- RECV:
  - `byte_ready`=1.
  - A byte transfers on a cycle where `byte_valid` and `byte_ready` are both high.
  - Byte n of the word (n=0..3) goes into bits [8n+7:8n], so the first byte received is the LSB.
  - The accept that completes the 4th byte moves the FSM to WRITE.
- WRITE:
  - `byte_ready`=0.
  - `mem_we`=1 for exactly one cycle, with `mem_addr` = word_idx×4 and `mem_wdata` = the assembled word.
  - Then word_idx increments. If this was the last word (word_idx = count−1 before incrementing), go to DONE; otherwise go to RECV with byte index 0.
- DONE: for one cycle, `cpu_hold`=0, `busy`=0, `done`=1, then go to IDLE. `done` stays 1 until the next `start`.
- After a write, `mem_addr` and `mem_wdata` hold their last values. `mem_we` is 0 outside WRITE.
- `start` is ignored in RECV, WRITE and DONE.
- `byte_valid` is ignored outside RECV, and such bytes are not consumed.
- Reset mid-load: asynchronous return to the reset values. The partial word is discarded. Words already written stay in memory; they are not this block's responsibility. The next load starts again at address 0.

## Timing

- Handshake: the producer must hold `byte_data` stable while `byte_valid`=1 and `byte_ready`=0. There is no combinational path from `byte_valid` to `byte_ready`.
- Write latency: the 4th byte is accepted at edge k; `mem_we`=1 during cycle k→k+1; the next byte can be accepted at edge k+2.
- Peak throughput: 4 bytes per 5 cycles.
- `cpu_hold` rises at the edge after `start` and falls at the edge after the last write. The core's first fetch therefore sees the complete image.
- Back-to-back start: a `start` in the cycle after DONE is legal.
- A 16-bit `word_count` larger than MEM_DEPTH is rejected; it does not wrap.

## Test plan

- Reset behaviour: drive `reset`=0 mid-simulation. All outputs must read 0 within the same cycle, asynchronously and without a clock edge.
- Two-word load, streamed back-to-back with `word_count`=2: send 13 05 00 00 93 05 10 00. Expect exactly two writes: addr 0x00000000 data 0x00000513, then addr 0x00000004 data 0x00100593. Expect `cpu_hold` high from the cycle after `start` until the cycle after the second write, then `done`=1 and `busy`=0.
- Throttled stream: same data as the two-word load with 0–3 idle cycles between bytes. Expect an identical write sequence, and `byte_ready` steadily 1 while in RECV.
- Illegal counts:
  - `word_count`=0: `error`=1, `mem_we` never asserted, `busy`=0, `cpu_hold`=0.
  - `word_count`=65 (MEM_DEPTH=64): same response.
- Interference and reset mid-load:
  - A `start` pulse during RECV has no effect on addresses.
  - Assert `reset` after 6 bytes: only addr 0 has been written and all outputs are 0.
  - A new `start` then writes its first word to addr 0.
- Full depth: `word_count`=64 with byte pattern i. Expect 64 writes; the last is at addr 0x000000FC with data {8'd255, 8'd254, 8'd253, 8'd252}. `done` then reads 1.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory
//
// Collects a little-endian byte stream into 32-bit words and writes them to
// consecutive word addresses starting at 0, holding the core in reset while
// the image is being written.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle load request (IDLE only)
//   word_count   number of words to load, sampled with start
//   byte_valid   byte_data carries a program byte
//   byte_data    program byte
//   byte_ready   loader accepts a byte this cycle
//   mem_we       one-cycle write strobe per word
//   mem_addr     byte address of the written word (multiple of 4)
//   mem_wdata    assembled word
//   cpu_hold     keeps the core in reset while high
//   busy         load in progress
//   done         sticky, last load completed
//   error        sticky, last start carried an illegal word_count
module imem_loader #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_COUNT = 16'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [15:0] count;
  logic [23:0] low_bytes;   // bytes 0..2 of the word being assembled

  logic count_ok;
  logic accept;
  logic last_word;

  // Full 16-bit compare so that oversized counts are rejected, never wrapped.
  assign count_ok  = (word_count != 16'd0) && (word_count <= MAX_COUNT);
  assign accept    = byte_valid && byte_ready;
  assign last_word = (word_idx == (count - 16'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      word_idx   <= 16'd0;
      count      <= 16'd0;
      low_bytes  <= 24'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done <= 1'b0;
            if (count_ok) begin
              count      <= word_count;
              error      <= 1'b0;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              byte_ready <= 1'b1;
              byte_idx   <= 2'd0;
              word_idx   <= 16'd0;
              state      <= RECV;
            end else begin
              error <= 1'b1;
            end
          end
        end

        RECV: begin
          if (accept) begin
            case (byte_idx)
              2'd0:    low_bytes[7:0]   <= byte_data;
              2'd1:    low_bytes[15:8]  <= byte_data;
              2'd2:    low_bytes[23:16] <= byte_data;
              default: begin
                // Fourth byte: present the word and strobe it next cycle.
                mem_wdata  <= {byte_data, low_bytes};
                mem_addr   <= {14'd0, word_idx, 2'b00};
                mem_we     <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end

        WRITE: begin
          mem_we   <= 1'b0;
          word_idx <= word_idx + 16'd1;
          byte_idx <= 2'd0;
          if (last_word) begin
            // Release the core on the edge right after the final write.
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int MEM_DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: tracks the load as "bytes collected so far" and
  // "words written so far", deriving each output from the load rules.
  bit          m_load, m_wr, m_cool;
  int          m_count, m_word;
  logic [7:0]  m_bytes[$];
  logic        e_ready, e_we, e_hold, e_busy, e_done, e_error;
  logic [31:0] e_addr, e_wdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_load = 0; m_wr = 0; m_cool = 0; m_count = 0; m_word = 0;
      m_bytes.delete();
      e_ready = 0; e_we = 0; e_hold = 0; e_busy = 0; e_done = 0; e_error = 0;
      e_addr = 0; e_wdata = 0;
    end else if (m_wr) begin
      m_wr = 0;
      e_we = 0;
      m_word++;
      if (m_word == m_count) begin
        m_load = 0; m_cool = 1;
        e_hold = 0; e_busy = 0; e_done = 1; e_ready = 0;
      end else begin
        e_ready = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (m_load) begin
      if (byte_valid && e_ready) begin
        m_bytes.push_back(byte_data);
        if (m_bytes.size() == 4) begin
          e_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          e_addr  = 32'(m_word * 4);
          e_we    = 1;
          e_ready = 0;
          m_wr    = 1;
          m_bytes.delete();
        end
      end
    end else if (start) begin
      e_done = 0;
      if (word_count >= 1 && int'(word_count) <= MEM_DEPTH) begin
        m_load = 1; m_count = int'(word_count); m_word = 0;
        m_bytes.delete();
        e_error = 0; e_busy = 1; e_hold = 1; e_ready = 1;
      end else begin
        e_error = 1;
      end
    end
  end

  // Observed write log, filled by the compare process.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(e_ready));
    chk("mem_we",     32'(mem_we),     32'(e_we));
    chk("mem_addr",   mem_addr,        e_addr);
    chk("mem_wdata",  mem_wdata,       e_wdata);
    chk("cpu_hold",   32'(cpu_hold),   32'(e_hold));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("done",       32'(done),       32'(e_done));
    chk("error",      32'(error),      32'(e_error));
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
  endtask

  // All drivers below act just after a falling edge.
  task automatic pulse_start(input logic [15:0] wc);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
    word_count = 16'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    repeat ($urandom_range(maxgap, 0)) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_image(input string tag, input logic [7:0] img[$], input int wc);
    chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'(wc));
    if (log_addr.size() == wc) begin
      for (int i = 0; i < wc; i++) begin
        chk({tag, "_addr"}, log_addr[i], 32'(4 * i));
        chk({tag, "_data"}, log_data[i],
            {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
      end
    end
  endtask

  logic [7:0] prog[$];
  logic [7:0] img[$];

  initial begin
    reset = 1'b0; start = 1'b0; word_count = 16'd0;
    byte_valid = 1'b0; byte_data = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;
    @(negedge clk);

    // Two-word back-to-back load with literal expectations.
    prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    clear_log();
    pulse_start(16'd2);
    chk("two_hold_after_start", 32'(cpu_hold), 32'd1);
    foreach (prog[i]) send_byte(prog[i], 0);
    wait_done("two");
    chk("two_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("two_addr0", log_addr[0], 32'h0000_0000);
      chk("two_data0", log_data[0], 32'h0000_0513);
      chk("two_addr1", log_addr[1], 32'h0000_0004);
      chk("two_data1", log_data[1], 32'h0010_0593);
    end
    chk("two_busy", 32'(busy), 32'd0);
    chk("two_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);

    // Throttled stream, same image.
    clear_log();
    pulse_start(16'd2);
    foreach (prog[i]) send_byte(prog[i], 3);
    wait_done("thr");
    check_image("thr", prog, 2);
    // start during the DONE cycle is ignored, start right after it is legal.
    pulse_start(16'd1);
    clear_log();
    pulse_start(16'd1);
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (img[i]) send_byte(img[i], 1);
    wait_done("b2b");
    chk("b2b_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) chk("b2b_data", log_data[0], 32'hDEAD_BEEF);
    @(negedge clk);

    // Illegal counts.
    clear_log();
    pulse_start(16'd0);
    chk("wc0_error", 32'(error), 32'd1);
    chk("wc0_busy", 32'(busy), 32'd0);
    chk("wc0_hold", 32'(cpu_hold), 32'd0);
    repeat (3) @(negedge clk);
    pulse_start(16'd65);
    chk("wc65_error", 32'(error), 32'd1);
    chk("wc65_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    pulse_start(16'hFFFF);
    chk("wcmax_error", 32'(error), 32'd1);
    repeat (3) @(negedge clk);
    chk("illegal_nwrites", 32'(log_addr.size()), 32'd0);

    // start pulse during RECV must not disturb addressing.
    clear_log();
    pulse_start(16'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) pulse_start(16'd1);
      send_byte(prog[i], 0);
    end
    wait_done("intf");
    check_image("intf", prog, 2);
    @(negedge clk);

    // Reset after six bytes, then a fresh load restarts at address 0.
    clear_log();
    pulse_start(16'd3);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 0);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    chk("rst_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) chk("rst_addr0", log_addr[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start(16'd1);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (img[i]) send_byte(img[i], 0);
    wait_done("after_rst");
    check_image("after_rst", img, 1);
    @(negedge clk);

    // Full depth with byte pattern i.
    clear_log();
    img.delete();
    for (int i = 0; i < 4 * MEM_DEPTH; i++) img.push_back(8'(i));
    pulse_start(16'(MEM_DEPTH));
    foreach (img[i]) send_byte(img[i], 1);
    wait_done("full");
    chk("full_nwrites", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() == 64) begin
      chk("full_last_addr", log_addr[63], 32'h0000_00FC);
      chk("full_last_data", log_data[63], 32'hFFFE_FDFC);
    end
    check_image("full", img, MEM_DEPTH);
    @(negedge clk);

    // Randomised loads, illegal requests and interfering starts.
    for (int t = 0; t < 12; t++) begin
      int wc;
      clear_log();
      if ($urandom_range(0, 4) == 0) begin
        pulse_start($urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(65, 65535)));
        chk("rnd_illegal_error", 32'(error), 32'd1);
        repeat (2) @(negedge clk);
        chk("rnd_illegal_nwrites", 32'(log_addr.size()), 32'd0);
      end else begin
        wc = $urandom_range(1, 4);
        img.delete();
        for (int i = 0; i < 4 * wc; i++) img.push_back(8'($urandom));
        pulse_start(16'(wc));
        foreach (img[i]) begin
          if ($urandom_range(0, 7) == 0) pulse_start(16'($urandom));
          send_byte(img[i], 3);
        end
        wait_done("rnd");
        check_image("rnd", img, wc);
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
